compare_seq_unit: RTL and testbench

//  Parametrised, multi-cycle successor to the single-cycle ALU comparator.

---
 rtl/compare_seq_unit_pkg.sv | 30 +++
 rtl/compare_seq_unit_chunk.sv | 14 +
 rtl/compare_seq_unit.sv | 142 ++++++++++++++
 tb/tb_compare_seq_unit.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/compare_seq_unit_pkg.sv
// Shared definitions for the sequential comparator: op codes, FSM encodings, helpers.
// COMPARE_SEQ_MINMAX_EN enables the min/max op codes 6..9.
package compare_seq_unit_pkg;

    localparam logic [3:0] CMP_NE   = 4'd0;
    localparam logic [3:0] CMP_EQ   = 4'd1;
    localparam logic [3:0] CMP_GE   = 4'd2;
    localparam logic [3:0] CMP_LT   = 4'd3;
    localparam logic [3:0] CMP_LTU  = 4'd4;
    localparam logic [3:0] CMP_GEU  = 4'd5;
    localparam logic [3:0] CMP_MIN  = 4'd6;
    localparam logic [3:0] CMP_MAX  = 4'd7;
    localparam logic [3:0] CMP_MINU = 4'd8;
    localparam logic [3:0] CMP_MAXU = 4'd9;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Signed ops get their operand MSBs inverted so the chunk walk stays unsigned.
    function automatic logic is_signed_op(input logic [3:0] op);
        logic s;
        s = (op == CMP_GE) || (op == CMP_LT);
`ifdef COMPARE_SEQ_MINMAX_EN
        s = s || (op == CMP_MIN) || (op == CMP_MAX);
`endif
        return s;
    endfunction

endpackage

// File: rtl/compare_seq_unit_chunk.sv
// Combinational CHUNK-wide unsigned compare producing {lt, eq}.
module compare_chunk #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             lt,
    output logic             eq
);

    assign lt = (a < b);
    assign eq = (a == b);

endmodule

// File: rtl/compare_seq_unit.sv
// Multi-cycle MSB-first chunked comparator with early termination and valid/ready handshakes.
// COMPARE_SEQ_MINMAX_EN adds signed/unsigned MIN/MAX ops returning the raw selected operand.
module compare_seq_unit
    import compare_seq_unit_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [3:0]       op_reg;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic [WIDTH-1:0] result_reg, result_next;
`ifdef COMPARE_SEQ_MINMAX_EN
    logic [WIDTH-1:0] src1_raw_reg, src2_raw_reg;
`endif

    logic [WIDTH-1:0] sign_mask;
    logic [CHUNK-1:0] a_chunks [NCHUNK];
    logic [CHUNK-1:0] b_chunks [NCHUNK];
    logic [CNT_W-1:0] chunk_idx;
    logic             chunk_lt, chunk_eq;
    logic             last_step;
    logic             accept;

    assign sign_mask = {is_signed_op(op), {(WIDTH-1){1'b0}}};

    genvar gi;
    generate
        for (gi = 0; gi < NCHUNK; gi++) begin : g_chunks
            assign a_chunks[gi] = a_reg[gi*CHUNK +: CHUNK];
            assign b_chunks[gi] = b_reg[gi*CHUNK +: CHUNK];
        end
    endgenerate

    // cnt counts from the MSB side; the array is indexed from the LSB side.
    assign chunk_idx = LAST - cnt_reg;

    compare_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a  (a_chunks[chunk_idx]),
        .b  (b_chunks[chunk_idx]),
        .lt (chunk_lt),
        .eq (chunk_eq)
    );

    assign last_step = !chunk_eq || (cnt_reg == LAST);
    assign accept    = in_valid && in_ready;
    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = (state_reg == ST_DONE);
    assign result    = result_reg;

    always_comb begin
        result_next = '0;
        case (op_reg)
            CMP_NE:  result_next[0] = !chunk_eq;
            CMP_EQ:  result_next[0] = chunk_eq;
            CMP_GE:  result_next[0] = !chunk_lt;
            CMP_LT:  result_next[0] = chunk_lt;
            CMP_LTU: result_next[0] = chunk_lt;
            CMP_GEU: result_next[0] = !chunk_lt;
`ifdef COMPARE_SEQ_MINMAX_EN
            // Ties resolve to src1 for both MIN and MAX.
            CMP_MIN, CMP_MINU: result_next = chunk_lt || chunk_eq ? src1_raw_reg : src2_raw_reg;
            CMP_MAX, CMP_MAXU: result_next = chunk_lt ? src2_raw_reg : src1_raw_reg;
`endif
            default: result_next = '0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_BUSY;
                    cnt_next   = '0;
                end
            end
            ST_BUSY: begin
                if (last_step) begin
                    state_next = ST_DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            op_reg     <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            result_reg <= '0;
`ifdef COMPARE_SEQ_MINMAX_EN
            src1_raw_reg <= '0;
            src2_raw_reg <= '0;
`endif
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                op_reg <= op;
                a_reg  <= src1 ^ sign_mask;
                b_reg  <= src2 ^ sign_mask;
`ifdef COMPARE_SEQ_MINMAX_EN
                src1_raw_reg <= src1;
                src2_raw_reg <= src2;
`endif
            end
            if (state_reg == ST_BUSY && last_step) begin
                result_reg <= result_next;
            end
        end
    end

endmodule

// File: tb/tb_compare_seq_unit.sv
// Directed bench for compare_seq_unit (WIDTH=64, CHUNK=16).
module tb_compare_seq_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] src1;
    logic [63:0] src2;
    logic [3:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    compare_seq_unit #(.WIDTH(64), .CHUNK(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .src1      (src1),
        .src2      (src2),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%016h expected 0x%016h", tag, obs, exp);
    endtask

    // One full transaction: accept, wait for out_valid, check latency and result, drain.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp_res,
                          input int exp_lat, input bit pre_ready);
        int lat;
        @(negedge clk);
        op = o; src1 = a; src2 = b; in_valid = 1'b1; out_ready = pre_ready;
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; src1 = ~a; src2 = 64'h0; op = 4'hF;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_result"}, result, exp_res);
        $display("op=%0d src1=0x%016h src2=0x%016h result=0x%016h latency=%0d", o, a, b, result, lat);
        if (!pre_ready) begin
            @(negedge clk);
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check({tag, "_drained"}, 64'(out_valid), 64'd0);
        check({tag, "_idle"}, 64'(in_ready), 64'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] held;
        int lat;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; src1 = '0; src2 = '0; op = '0;
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("eq_equal", 4'd1, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 64'd1, 4, 1'b0);
        run_op("ne_equal", 4'd0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 64'd0, 4, 1'b0);

        // Reset mid-walk: accept an equal-operand LTU, assert rst once cnt reaches 2.
        run_op("eq_again", 4'd1, 64'h5, 64'h5, 64'd1, 4, 1'b0);
        @(negedge clk);
        op = 4'd4; src1 = 64'hAAAA_BBBB_CCCC_DDDD; src2 = 64'hAAAA_BBBB_CCCC_DDDD; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_result", result, 64'd0);
        $display("op=4 reset asserted mid-walk out_valid=%0b in_ready=%0b result=0x%016h", out_valid, in_ready, result);
        @(negedge clk);
        rst = 1'b0;
        run_op("post_rst_ltu", 4'd4, 64'h1, 64'h2, 64'd1, 4, 1'b0);

        run_op("lt_signed_edge", 4'd3, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1, 1'b0);
        run_op("ltu_edge", 4'd4, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 1, 1'b0);
        run_op("ge_signed_edge", 4'd2, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 1, 1'b1);
        run_op("geu_chunk1", 4'd5, 64'h0000_0000_0001_0000, 64'h0000_0000_0000_FFFF, 64'd1, 3, 1'b0);
        run_op("ne_chunk2", 4'd0, 64'h1234_0001_0000_0000, 64'h1234_0002_0000_0000, 64'd1, 2, 1'b1);
        run_op("bad_op", 4'd12, 64'h1, 64'h2, 64'd0, 4, 1'b0);

        // Back-pressure: hold out_ready low in DONE while a second request waits.
        @(negedge clk);
        op = 4'd4; src1 = 64'h0; src2 = 64'h1; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        op = 4'd1; src1 = 64'h9; src2 = 64'h9;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
        end
        check("bp_latency", 64'(lat), 64'd4);
        held = result;
        check("bp_result", held, 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_out_valid_hold", 64'(out_valid), 64'd1);
            check("bp_result_hold", result, held);
            check("bp_in_ready_low", 64'(in_ready), 64'd0);
        end
        $display("op=4 src1=0x0 src2=0x1 result=0x%016h held 5 cycles", result);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_fire_out_valid", 64'(out_valid), 64'd0);
        check("bp_fire_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_second_accepted", 64'(in_ready), 64'd0);
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
        end
        check("bp_second_latency", 64'(lat), 64'd4);
        check("bp_second_result", result, 64'd1);
        $display("op=1 src1=0x9 src2=0x9 result=0x%016h latency=%0d", result, lat);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_second_drained", 64'(out_valid), 64'd0);

`ifdef COMPARE_SEQ_MINMAX_EN
        run_op("min_signed", 4'd6, 64'hFFFF_FFFF_FFFF_FFFE, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1, 1'b0);
        run_op("min_unsigned", 4'd8, 64'hFFFF_FFFF_FFFF_FFFE, 64'd5, 64'd5, 1, 1'b0);
        run_op("max_signed", 4'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd5, 64'd5, 1, 1'b0);
        run_op("maxu_tie", 4'd9, 64'h0000_1111_0000_2222, 64'h0000_1111_0000_2222, 64'h0000_1111_0000_2222, 4, 1'b0);
`else
        run_op("min_disabled", 4'd6, 64'hFFFF_FFFF_FFFF_FFFE, 64'd5, 64'd0, 1, 1'b0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
